// File: rtl/pll_reconfig_pkg.sv
// ----------------------------------------------------------------------------
// pll_reconfig_pkg
//   Shared definitions for the PLL reconfiguration sequencer:
//   - altera_pll_reconfig register addresses (MODE/STATUS/START/N/M/C)
//   - counter word and C-select field widths
//   - sequencer state enum
//   - helpers that pack counter values into 32-bit write data
// ----------------------------------------------------------------------------
package pll_reconfig_pkg;

   // Reconfig core register map (word addresses on the 6-bit mgmt bus)
   localparam logic [5:0] ADDR_MODE   = 6'h00;
   localparam logic [5:0] ADDR_STATUS = 6'h01;
   localparam logic [5:0] ADDR_START  = 6'h02;
   localparam logic [5:0] ADDR_N      = 6'h03;
   localparam logic [5:0] ADDR_M      = 6'h04;
   localparam logic [5:0] ADDR_C      = 6'h05;

   // Counter word is {odd, bypass, hi[7:0], lo[7:0]}
   localparam int CNT_WORD_W = 18;
   // C counter select field sits directly above the counter word
   localparam int CSEL_W     = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_MODE,
      ST_WR_N,
      ST_WR_M,
      ST_WR_C,
      ST_WR_START,
      ST_WAIT_LOCK,
      ST_PLL_RST
   } seq_state_e;

   // N / M write data: counter word zero-extended to the bus width
   function automatic logic [31:0] nm_word(input logic [CNT_WORD_W-1:0] val);
      return {14'b0, val};
   endfunction

   // C write data: counter select in [22:18], counter word in [17:0]
   function automatic logic [31:0] c_word(input logic [CSEL_W-1:0]     sel,
                                          input logic [CNT_WORD_W-1:0] val);
      return {9'b0, sel, val};
   endfunction

endpackage

// File: rtl/pll_lock_mon.sv
// ----------------------------------------------------------------------------
// pll_lock_mon
//   Supervises PLL relock. Synchronises the asynchronous pll_locked into the
//   clk domain, counts consecutive locked cycles and total waiting cycles.
//   Both counters saturate at their thresholds and are held at zero while
//   clear is high.
// Ports
//   clk, reset_n   clock, synchronous active-low reset
//   clear          hold both counters at zero (sequencer not waiting)
//   pll_locked     raw PLL lock indication (asynchronous)
//   lock_ok        LOCK_STABLE consecutive synchronised locked cycles seen
//   lock_timeout   LOCK_TIMEOUT cycles elapsed since clear was released
// ----------------------------------------------------------------------------
module pll_lock_mon #(
   parameter int LOCK_STABLE  = 256,
   parameter int LOCK_TIMEOUT = 65536
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic pll_locked,
   output logic lock_ok,
   output logic lock_timeout
);

   localparam int STB_W = $clog2(LOCK_STABLE + 1);
   localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [STB_W-1:0] STB_MAX = STB_W'(LOCK_STABLE);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(LOCK_TIMEOUT);

   logic             locked_meta_d, locked_meta_q;
   logic             locked_sync_d, locked_sync_q;
   logic [STB_W-1:0] stable_d, stable_q;
   logic [TMO_W-1:0] timeout_d, timeout_q;

   always_comb begin
      // NOTE: every _d gets a default before any branch, so no path can leave
      // it unassigned and infer a latch.
      locked_meta_d = pll_locked;
      locked_sync_d = locked_meta_q;
      stable_d      = stable_q;
      timeout_d     = timeout_q;

      if (clear) begin
         stable_d  = '0;
         timeout_d = '0;
      end else begin
         // Any unlocked cycle restarts the stability window
         if (!locked_sync_q) begin
            stable_d = '0;
         end else if (stable_q != STB_MAX) begin
            stable_d = stable_q + STB_W'(1);
         end
         if (timeout_q != TMO_MAX) begin
            timeout_d = timeout_q + TMO_W'(1);
         end
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         locked_meta_q <= 1'b0;
         locked_sync_q <= 1'b0;
         stable_q      <= '0;
         timeout_q     <= '0;
      end else begin
         locked_meta_q <= locked_meta_d;
         locked_sync_q <= locked_sync_d;
         stable_q      <= stable_d;
         timeout_q     <= timeout_d;
      end
   end

   assign lock_ok      = (stable_q == STB_MAX);
   assign lock_timeout = (timeout_q == TMO_MAX);

endmodule

// File: rtl/pll_reconfig_seq.sv
// ----------------------------------------------------------------------------
// pll_reconfig_seq
//   Drives the altera_pll_reconfig Avalon-MM slave to reprogram the fabric
//   PLL: MODE, N, M, the enabled C counters, then START. Afterwards it waits
//   for a stable lock, pulsing pll_rst and retrying on lock timeout.
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   cfg_start             one-cycle request, honoured only when idle
//   cfg_n, cfg_m          N / M counter words
//   cfg_c, cfg_c_en       C counter words (k at [18k+17:18k]) and write enables
//   busy                  sequence in progress
//   done, error           one-cycle completion / failure pulses
//   mgmt_address/write/writedata, mgmt_waitrequest   reconfig core master port
//   pll_locked            raw PLL lock (synchronised in pll_lock_mon)
//   pll_rst               PLL reset, active high
// ----------------------------------------------------------------------------
module pll_reconfig_seq
   import pll_reconfig_pkg::*;
#(
   parameter int NUM_C        = 3,
   parameter int LOCK_STABLE  = 256,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int RST_CYCLES   = 16,
   parameter int MAX_RETRY    = 3,
   parameter int BUS_TIMEOUT  = 1024
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        cfg_start,
   input  logic [CNT_WORD_W-1:0]       cfg_n,
   input  logic [CNT_WORD_W-1:0]       cfg_m,
   input  logic [NUM_C*CNT_WORD_W-1:0] cfg_c,
   input  logic [NUM_C-1:0]            cfg_c_en,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [5:0]                  mgmt_address,
   output logic                        mgmt_write,
   output logic [31:0]                 mgmt_writedata,
   input  logic                        mgmt_waitrequest,
   input  logic                        pll_locked,
   output logic                        pll_rst
);

   localparam int BUS_W = $clog2(BUS_TIMEOUT + 1);
   localparam int RST_W = $clog2(RST_CYCLES + 1);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);
   localparam logic [BUS_W-1:0] BUS_LAST = BUS_W'(BUS_TIMEOUT - 1);
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   seq_state_e                  state_d, state_q;
   logic                        busy_d, busy_q;
   logic                        done_d, done_q;
   logic                        error_d, error_q;
   logic                        write_d, write_q;
   logic [5:0]                  addr_d, addr_q;
   logic [31:0]                 data_d, data_q;
   logic                        pll_rst_d, pll_rst_q;
   logic [BUS_W-1:0]            bus_cnt_d, bus_cnt_q;
   logic [RST_W-1:0]            rst_cnt_d, rst_cnt_q;
   logic [RTY_W-1:0]            retry_d, retry_q;
   logic [CSEL_W-1:0]           c_idx_d, c_idx_q;
   logic [NUM_C-1:0]            c_pend_d, c_pend_q;
   logic [CNT_WORD_W-1:0]       cfg_n_d, cfg_n_q;
   logic [CNT_WORD_W-1:0]       cfg_m_d, cfg_m_q;
   logic [NUM_C*CNT_WORD_W-1:0] cfg_c_d, cfg_c_q;

   logic                        lock_clear;
   logic                        lock_ok;
   logic                        lock_timeout;
   logic                        in_write;
   logic [NUM_C-1:0]            c_rem;
   logic [CSEL_W-1:0]           first_pend;
   logic [CSEL_W-1:0]           first_rem;

   // Lowest set index of an enable mask (0 when the mask is empty)
   function automatic logic [CSEL_W-1:0] first_set(input logic [NUM_C-1:0] v);
      logic [CSEL_W-1:0] idx;
      idx = '0;
      for (int k = NUM_C - 1; k >= 0; k--) begin
         if (v[k]) idx = CSEL_W'(k);
      end
      return idx;
   endfunction

   function automatic logic [CNT_WORD_W-1:0] c_val(input logic [NUM_C*CNT_WORD_W-1:0] all,
                                                   input logic [CSEL_W-1:0]           sel);
      return all[int'(sel)*CNT_WORD_W +: CNT_WORD_W];
   endfunction

   pll_lock_mon #(
      .LOCK_STABLE  (LOCK_STABLE),
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
   ) u_lock_mon (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (lock_clear),
      .pll_locked   (pll_locked),
      .lock_ok      (lock_ok),
      .lock_timeout (lock_timeout)
   );

   // Lock counters run only while waiting, so each wait starts from zero
   assign lock_clear = (state_q != ST_WAIT_LOCK);

   assign in_write   = state_q inside {ST_WR_MODE, ST_WR_N, ST_WR_M, ST_WR_C, ST_WR_START};
   // Pending C mask once the counter currently on the bus has been written
   assign c_rem      = c_pend_q & ~(NUM_C'(1) << c_idx_q);
   assign first_pend = first_set(c_pend_q);
   assign first_rem  = first_set(c_rem);

   // Next-state and next-output logic. Outputs are registered: whatever is
   // computed here for the next state appears on the bus on that state's
   // first cycle, so each write is presented the cycle after the previous
   // one is accepted.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      write_d   = write_q;
      addr_d    = addr_q;
      data_d    = data_q;
      pll_rst_d = pll_rst_q;
      bus_cnt_d = bus_cnt_q;
      rst_cnt_d = rst_cnt_q;
      retry_d   = retry_q;
      c_idx_d   = c_idx_q;
      c_pend_d  = c_pend_q;
      cfg_n_d   = cfg_n_q;
      cfg_m_d   = cfg_m_q;
      cfg_c_d   = cfg_c_q;

      // Stall cycles of the current write; restarts with every new transfer
      if (in_write) begin
         bus_cnt_d = mgmt_waitrequest ? bus_cnt_q + BUS_W'(1) : '0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               cfg_n_d   = cfg_n;
               cfg_m_d   = cfg_m;
               cfg_c_d   = cfg_c;
               c_pend_d  = cfg_c_en;
               retry_d   = '0;
               bus_cnt_d = '0;
               busy_d    = 1'b1;
               write_d   = 1'b1;
               addr_d    = ADDR_MODE;
               data_d    = '0;
               state_d   = ST_WR_MODE;
            end
         end

         ST_WR_MODE: begin
            if (!mgmt_waitrequest) begin
               addr_d  = ADDR_N;
               data_d  = nm_word(cfg_n_q);
               state_d = ST_WR_N;
            end
         end

         ST_WR_N: begin
            if (!mgmt_waitrequest) begin
               addr_d  = ADDR_M;
               data_d  = nm_word(cfg_m_q);
               state_d = ST_WR_M;
            end
         end

         ST_WR_M: begin
            if (!mgmt_waitrequest) begin
               if (|c_pend_q) begin
                  c_idx_d = first_pend;
                  addr_d  = ADDR_C;
                  data_d  = c_word(first_pend, c_val(cfg_c_q, first_pend));
                  state_d = ST_WR_C;
               end else begin
                  addr_d  = ADDR_START;
                  data_d  = '0;
                  state_d = ST_WR_START;
               end
            end
         end

         ST_WR_C: begin
            if (!mgmt_waitrequest) begin
               c_pend_d = c_rem;
               if (|c_rem) begin
                  c_idx_d = first_rem;
                  data_d  = c_word(first_rem, c_val(cfg_c_q, first_rem));
               end else begin
                  addr_d  = ADDR_START;
                  data_d  = '0;
                  state_d = ST_WR_START;
               end
            end
         end

         ST_WR_START: begin
            if (!mgmt_waitrequest) begin
               write_d = 1'b0;
               state_d = ST_WAIT_LOCK;
            end
         end

         ST_WAIT_LOCK: begin
            // A lock that completes on the timeout cycle still counts as success
            if (lock_ok) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (lock_timeout) begin
               if (retry_q != RTY_MAX) begin
                  retry_d   = retry_q + RTY_W'(1);
                  rst_cnt_d = '0;
                  pll_rst_d = 1'b1;
                  state_d   = ST_PLL_RST;
               end else begin
                  error_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end

         ST_PLL_RST: begin
            if (rst_cnt_q == RST_LAST) begin
               pll_rst_d = 1'b0;
               state_d   = ST_WAIT_LOCK;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A write stalled for BUS_TIMEOUT cycles abandons the whole sequence
      if (in_write && mgmt_waitrequest && (bus_cnt_q == BUS_LAST)) begin
         write_d = 1'b0;
         error_d = 1'b1;
         busy_d  = 1'b0;
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         pll_rst_q <= 1'b0;
         bus_cnt_q <= '0;
         rst_cnt_q <= '0;
         retry_q   <= '0;
         c_idx_q   <= '0;
         c_pend_q  <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         pll_rst_q <= pll_rst_d;
         bus_cnt_q <= bus_cnt_d;
         rst_cnt_q <= rst_cnt_d;
         retry_q   <= retry_d;
         c_idx_q   <= c_idx_d;
         c_pend_q  <= c_pend_d;
      end
   end

   // NOTE: the configuration capture registers have no reset; they are
   // loaded on every accepted cfg_start before anything reads them.
   always_ff @(posedge clk) begin
      cfg_n_q <= cfg_n_d;
      cfg_m_q <= cfg_m_d;
      cfg_c_q <= cfg_c_d;
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign mgmt_write     = write_q;
   assign mgmt_address   = addr_q;
   assign mgmt_writedata = data_q;
   assign pll_rst        = pll_rst_q;

endmodule
